// File: rtl/icache_fb_pkg.sv
// Shared constants, pointer sizing and entry layout for the fetch-to-icache request buffer.
package icache_fb_pkg;

    localparam int unsigned FB_ADR_WIDTH    = 64;
    localparam int unsigned FB_RETURN_BYTES = 16;
    localparam int unsigned FB_DEPTH        = 4;
    localparam int unsigned FB_DATA_WIDTH   = FB_RETURN_BYTES * 8;

    // One extra bit over the index so full and empty are distinguishable.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic [FB_ADR_WIDTH-1:0]  addr;
        logic [FB_DATA_WIDTH-1:0] data;
    } fb_entry_t;

endpackage

// File: rtl/icache_fb_store.sv
// Entry storage: address written at tail, data written at resp, read at issue and head.
module icache_fb_store import icache_fb_pkg::*; #(
    parameter int unsigned ADR_WIDTH  = FB_ADR_WIDTH,
    parameter int unsigned DATA_WIDTH = FB_DATA_WIDTH,
    parameter int unsigned DEPTH      = FB_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       addr_we,
    input  logic [$clog2(DEPTH)-1:0]   addr_idx,
    input  logic [ADR_WIDTH-1:0]       addr_wdata,
    input  logic                       data_we,
    input  logic [$clog2(DEPTH)-1:0]   data_idx,
    input  logic [DATA_WIDTH-1:0]      data_wdata,
    input  logic [$clog2(DEPTH)-1:0]   issue_idx,
    input  logic [$clog2(DEPTH)-1:0]   head_idx,
    output logic [ADR_WIDTH-1:0]       issue_addr,
    output logic [ADR_WIDTH-1:0]       head_addr,
    output logic [DATA_WIDTH-1:0]      head_data
);

    logic [ADR_WIDTH-1:0]  addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) addr_mem[i] <= '0;
        end else if (addr_we) begin
            addr_mem[addr_idx] <= addr_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) data_mem[i] <= '0;
        end else if (data_we) begin
            data_mem[data_idx] <= data_wdata;
        end
    end

    assign issue_addr = addr_mem[issue_idx];
    assign head_addr  = addr_mem[head_idx];
    assign head_data  = data_mem[head_idx];

endmodule

// File: rtl/icache_fetch_buffer.sv
// Circular request/response buffer between fetch and the icache with miss replay and flush.
module icache_fetch_buffer import icache_fb_pkg::*; #(
    parameter int unsigned ADR_WIDTH    = FB_ADR_WIDTH,
    parameter int unsigned RETURN_BYTES = FB_RETURN_BYTES,
    parameter int unsigned DEPTH        = FB_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        f_req_valid,
    input  logic [ADR_WIDTH-1:0]        f_req_addr,
    output logic                        f_req_ready,
    output logic                        c_req_valid,
    output logic [ADR_WIDTH-1:0]        c_req_addr,
    input  logic                        c_req_ready,
    input  logic                        c_resp_valid,
    input  logic [RETURN_BYTES*8-1:0]   c_resp_data,
    input  logic                        c_resp_miss,
    output logic                        p_valid,
    output logic [ADR_WIDTH-1:0]        p_addr,
    output logic [RETURN_BYTES*8-1:0]   p_data,
    input  logic                        p_ready,
    output logic                        miss_pulse
);

    localparam int unsigned DATA_WIDTH = RETURN_BYTES * 8;
    localparam int unsigned PW         = ptr_width(DEPTH);
    localparam int unsigned IW         = PW - 1;

    typedef logic [PW-1:0] ptr_t;

    ptr_t head_q, resp_q, issue_q, tail_q, drop_q;
    ptr_t head_d, resp_d, issue_d, tail_d, drop_d;
    logic miss_pulse_q, miss_pulse_d;

    logic                  full, accept, c_hs, p_hs;
    logic                  resp_live, resp_ok, resp_miss;
    logic [ADR_WIDTH-1:0]  issue_addr, head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    assign full        = (tail_q - head_q) == ptr_t'(DEPTH);
    assign f_req_ready = !full && !flush;
    assign c_req_valid = (issue_q != tail_q) && !flush;
    assign p_valid     = head_q != resp_q;

    assign accept    = f_req_valid && f_req_ready;
    assign c_hs      = c_req_valid && c_req_ready;
    assign p_hs      = p_valid && p_ready;
    assign resp_live = c_resp_valid && (drop_q == '0);
    assign resp_ok   = resp_live && !c_resp_miss;
    assign resp_miss = resp_live && c_resp_miss;

    // Pointer and drop-count update; miss overrides issue, flush overrides everything.
    always_comb begin
        head_d       = head_q;
        resp_d       = resp_q;
        issue_d      = issue_q;
        tail_d       = tail_q;
        drop_d       = drop_q;
        miss_pulse_d = 1'b0;

        if (accept)                         tail_d  = tail_q + ptr_t'(1);
        if (c_hs)                           issue_d = issue_q + ptr_t'(1);
        if (p_hs)                           head_d  = head_q + ptr_t'(1);
        if (c_resp_valid && drop_q != '0)   drop_d  = drop_q - ptr_t'(1);
        if (resp_ok)                        resp_d  = resp_q + ptr_t'(1);

        if (resp_miss) begin
            issue_d      = resp_q;
            drop_d       = issue_q - resp_q - ptr_t'(1) + ptr_t'(c_hs);
            miss_pulse_d = 1'b1;
        end

        // Everything the cache still owes us, pending drops included, becomes a drop.
        if (flush) begin
            head_d       = '0;
            resp_d       = '0;
            issue_d      = '0;
            tail_d       = '0;
            drop_d       = drop_q + issue_q - resp_q + ptr_t'(c_hs) - ptr_t'(c_resp_valid);
            miss_pulse_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q       <= '0;
            resp_q       <= '0;
            issue_q      <= '0;
            tail_q       <= '0;
            drop_q       <= '0;
            miss_pulse_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            resp_q       <= resp_d;
            issue_q      <= issue_d;
            tail_q       <= tail_d;
            drop_q       <= drop_d;
            miss_pulse_q <= miss_pulse_d;
        end
    end

    icache_fb_store #(
        .ADR_WIDTH  (ADR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_store (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr_we    (accept),
        .addr_idx   (tail_q[IW-1:0]),
        .addr_wdata (f_req_addr),
        .data_we    (resp_ok && !flush),
        .data_idx   (resp_q[IW-1:0]),
        .data_wdata (c_resp_data),
        .issue_idx  (issue_q[IW-1:0]),
        .head_idx   (head_q[IW-1:0]),
        .issue_addr (issue_addr),
        .head_addr  (head_addr),
        .head_data  (head_data)
    );

    assign c_req_addr = c_req_valid ? issue_addr : '0;
    assign p_addr     = p_valid ? head_addr : '0;
    assign p_data     = p_valid ? head_data : '0;
    assign miss_pulse = miss_pulse_q;

endmodule
